lru_bit_writer: RTL and testbench

- Write side of the per-set LRU state for the 2-way set-associative cache: owns the 256 LRU bits and drives them as a flat 256-bit bus into the 256:1 LRU read mux.
- Applies per-access LRU updates from the cache controller.
- Runs a sequential flush sweep that returns every set to the reset LRU value.
- Counts accepted updates for performance monitoring.

---
 rtl/lru_bit_writer_if.sv | 23 ++
 rtl/lru_bit_writer.sv | 81 ++++++++
 tb/tb_lru_bit_writer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lru_bit_writer_if.sv
// Update handshake between the cache controller (master) and the LRU bit writer (slave).
interface lru_bit_writer_if #(
    parameter int IDX_W = 8
);
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_way;
    logic             upd_ready;

    modport master (
        output upd_valid,
        output upd_index,
        output upd_way,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_index,
        input  upd_way,
        output upd_ready
    );
endinterface

// File: rtl/lru_bit_writer.sv
// Owns the per-set LRU bits of a 2-way cache: applies access updates, runs a
// full-array flush sweep, and counts accepted updates.
module lru_bit_writer #(
    parameter int   SETS      = 256,
    parameter int   IDX_W     = 8,
    parameter logic FLUSH_VAL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    lru_bit_writer_if.slave     upd,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                flush_done,
    output logic [SETS-1:0]     stored_bits,
    output logic [15:0]         upd_count
);
    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    state_t           state;
    logic [IDX_W-1:0] counter;

    // Flush has priority over an update presented in the same cycle.
    assign upd.upd_ready = (state == IDLE) && !flush_req;

    // NOTE: stored_bits is a bank of flops, not a RAM, so it can and must take
    // the async reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stored_bits <= {SETS{FLUSH_VAL}};
            state       <= IDLE;
            counter     <= '0;
            flush_busy  <= 1'b0;
            flush_done  <= 1'b0;
            upd_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_done <= 1'b0;
                    if (flush_req) begin
                        state      <= SWEEP;
                        counter    <= '0;
                        flush_busy <= 1'b1;
                    end else if (upd.upd_valid) begin
                        // Bit holds the least-recently-used way: the next victim.
                        stored_bits[upd.upd_index] <= ~upd.upd_way;
                        if (upd_count != 16'hFFFF) begin
                            upd_count <= upd_count + 16'd1;
                        end
                    end
                end

                SWEEP: begin
                    stored_bits[counter] <= FLUSH_VAL;
                    counter              <= counter + 1'b1;
                    if (counter == LAST_IDX) begin
                        state      <= DONE;
                        flush_busy <= 1'b0;
                        flush_done <= 1'b1;
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    flush_done <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    flush_busy <= 1'b0;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lru_bit_writer.sv
// Scoreboard bench for lru_bit_writer: expected LRU bits and counts are queued
// at drive time and compared after the clock edge that applies them.
module tb_lru_bit_writer;
    localparam int SETS  = 256;
    localparam int IDX_W = 8;

    typedef struct {
        logic [SETS-1:0] bits;
        logic [15:0]     count;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush_req;
    logic            flush_busy;
    logic            flush_done;
    logic [SETS-1:0] stored_bits;
    logic [15:0]     upd_count;

    int checks   = 0;
    int failures = 0;

    exp_t            exp_q[$];
    logic [SETS-1:0] m_bits;
    logic [15:0]     m_count;

    always #5 clk = ~clk;

    lru_bit_writer_if #(.IDX_W(IDX_W)) upd ();

    lru_bit_writer #(
        .SETS(SETS),
        .IDX_W(IDX_W),
        .FLUSH_VAL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .upd(upd),
        .flush_req(flush_req),
        .flush_busy(flush_busy),
        .flush_done(flush_done),
        .stored_bits(stored_bits),
        .upd_count(upd_count)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // Model of an accepted update; the resulting state is queued for comparison.
    task automatic model_accept(input logic [IDX_W-1:0] idx, input logic way);
        m_bits[idx] = ~way;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        exp_q.push_back('{m_bits, m_count});
    endtask

    // Leaves the bench 1 time unit after a rising edge with rst released.
    task automatic apply_reset();
        upd.upd_valid = 1'b0;
        flush_req     = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        m_bits  = '0;
        m_count = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        // Power-on reset is held from time 0.
        #1;
        checks++;
        if (stored_bits !== '0 || upd_count !== 16'd0 || flush_busy !== 1'b0 || flush_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: bits=%h count=%h busy=%b done=%b required all zero",
                     stored_bits, upd_count, flush_busy, flush_done);
        end
        checks++;
        if (upd.upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_idle: upd_ready=%b required 1", upd.upd_ready);
        end
        flush_req = 1'b1;
        #1;
        checks++;
        if (upd.upd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_flushreq: upd_ready=%b required 0", upd.upd_ready);
        end
        flush_req      = 1'b0;
        upd.upd_valid  = 1'b1;
        upd.upd_index  = 8'd9;
        upd.upd_way    = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (stored_bits !== '0 || upd_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_no_write: bits=%h count=%h required zero", stored_bits, upd_count);
        end
        // Release, apply one update, then reset asynchronously mid-cycle.
        rst     = 1'b0;
        m_bits  = '0;
        m_count = '0;
        model_accept(8'd9, 1'b0);
        @(posedge clk); #1;
        upd.upd_valid = 1'b0;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL reset_preload: scoreboard empty, required one entry");
        end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (stored_bits !== e.bits || upd_count !== e.count) begin
                failures++;
                $display("FAIL reset_preload: bits=%h count=%h required bits=%h count=%h",
                         stored_bits, upd_count, e.bits, e.count);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (stored_bits !== '0 || upd_count !== 16'd0 || flush_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: bits=%h count=%h busy=%b required zero",
                     stored_bits, upd_count, flush_busy);
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        m_bits  = '0;
        m_count = '0;
    endtask

    task automatic test_single_update();
        logic [IDX_W-1:0] idx_tab[2] = '{8'd37, 8'd37};
        logic             way_tab[2] = '{1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            upd.upd_valid = 1'b1;
            upd.upd_index = idx_tab[i];
            upd.upd_way   = way_tab[i];
            #1;
            checks++;
            if (upd.upd_ready !== 1'b1 || stored_bits !== m_bits) begin
                failures++;
                $display("FAIL single_pre_%0d: ready=%b bits=%h required ready=1 bits=%h",
                         i, upd.upd_ready, stored_bits, m_bits);
            end
            model_accept(idx_tab[i], way_tab[i]);
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL single_%0d: scoreboard empty, required one entry", i);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (stored_bits !== e.bits || upd_count !== e.count) begin
                    failures++;
                    $display("FAIL single_%0d: bits=%h count=%h required bits=%h count=%h",
                             i, stored_bits, upd_count, e.bits, e.count);
                end
            end
        end
        upd.upd_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [IDX_W-1:0] idx_tab[5] = '{8'd0, 8'd255, 8'd128, 8'd5, 8'd5};
        logic             way_tab[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            upd.upd_valid = 1'b1;
            upd.upd_index = idx_tab[i];
            upd.upd_way   = way_tab[i];
            model_accept(idx_tab[i], way_tab[i]);
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL b2b_%0d: scoreboard empty, required one entry", i);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (stored_bits !== e.bits || upd_count !== e.count) begin
                    failures++;
                    $display("FAIL b2b_%0d: bits=%h count=%h required bits=%h count=%h",
                             i, stored_bits, upd_count, e.bits, e.count);
                end
            end
        end
        upd.upd_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic [IDX_W-1:0] pre_idx[3] = '{8'd0, 8'd100, 8'd255};
        logic [SETS-1:0]  pre_bits;
        int busy_cnt  = 0;
        int done_cnt  = 0;
        int done_at   = -1;
        int ready_cnt = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            upd.upd_valid = 1'b1;
            upd.upd_index = pre_idx[i];
            upd.upd_way   = 1'b0;
            model_accept(pre_idx[i], 1'b0);
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL flush_preload_%0d: scoreboard empty, required one entry", i);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (stored_bits !== e.bits || upd_count !== e.count) begin
                    failures++;
                    $display("FAIL flush_preload_%0d: bits=%h count=%h required bits=%h count=%h",
                             i, stored_bits, upd_count, e.bits, e.count);
                end
            end
        end
        pre_bits = m_bits;
        // Update to set 7 presented together with the flush request must be dropped.
        upd.upd_valid = 1'b1;
        upd.upd_index = 8'd7;
        upd.upd_way   = 1'b0;
        flush_req     = 1'b1;
        #1;
        checks++;
        if (upd.upd_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready_req: upd_ready=%b required 0", upd.upd_ready);
        end
        @(posedge clk); #1;
        flush_req     = 1'b0;
        upd.upd_valid = 1'b0;
        // Sample k is taken just after the k-th edge following the request edge.
        for (int k = 0; k < 260; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (flush_busy === 1'b1) busy_cnt++;
            if (flush_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k <= 256 && upd.upd_ready !== 1'b0) ready_cnt++;
            if (k == 0) begin
                checks++;
                if (stored_bits !== pre_bits) begin
                    failures++;
                    $display("FAIL flush_dropped_upd: bits=%h required %h", stored_bits, pre_bits);
                end
            end
            if (k == 100) begin
                checks++;
                if (stored_bits[100] !== 1'b1) begin
                    failures++;
                    $display("FAIL flush_bit100_early: bit=%b required 1", stored_bits[100]);
                end
            end
            if (k == 101) begin
                checks++;
                if (stored_bits[100] !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_bit100_cleared: bit=%b required 0", stored_bits[100]);
                end
            end
        end
        checks++;
        if (busy_cnt != 256) begin
            failures++;
            $display("FAIL flush_busy_len: cycles=%0d required 256", busy_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_at != 256) begin
            failures++;
            $display("FAIL flush_done_pulse: pulses=%0d at=%0d required 1 at 256", done_cnt, done_at);
        end
        checks++;
        if (ready_cnt != 0) begin
            failures++;
            $display("FAIL flush_ready_busy: ready_high_cycles=%0d required 0", ready_cnt);
        end
        checks++;
        if (stored_bits !== '0 || upd_count !== 16'd3 || upd.upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_final: bits=%h count=%h ready=%b required bits=0 count=3 ready=1",
                     stored_bits, upd_count, upd.upd_ready);
        end
    endtask

    task automatic test_reset_mid_flush();
        int done_cnt = 0;
        int busy_cnt = 0;
        apply_reset();
        upd.upd_valid = 1'b1;
        upd.upd_index = 8'd200;
        upd.upd_way   = 1'b0;
        @(posedge clk); #1;
        upd.upd_valid = 1'b0;
        flush_req     = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (stored_bits !== '0 || flush_busy !== 1'b0 || flush_done !== 1'b0 || upd.upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midflush_reset: bits=%h busy=%b done=%b ready=%b required 0 0 0 1",
                     stored_bits, flush_busy, flush_done, upd.upd_ready);
        end
        #2;
        rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (flush_done === 1'b1) done_cnt++;
            if (flush_busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (done_cnt != 0 || busy_cnt != 0 || stored_bits !== '0 || upd_count !== 16'd0) begin
            failures++;
            $display("FAIL midflush_after: done=%0d busy=%0d bits=%h count=%h required all zero",
                     done_cnt, busy_cnt, stored_bits, upd_count);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 65537; i++) begin
            upd.upd_valid = 1'b1;
            upd.upd_index = i[7:0];
            upd.upd_way   = i[8];
            m_bits[i[7:0]] = ~i[8];
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            @(posedge clk); #1;
            if (i == 65533) begin
                checks++;
                if (upd_count !== 16'hFFFE) begin
                    failures++;
                    $display("FAIL sat_near: count=%h required fffe", upd_count);
                end
            end
        end
        upd.upd_valid = 1'b0;
        checks++;
        if (upd_count !== 16'hFFFF || upd_count !== m_count) begin
            failures++;
            $display("FAIL sat_hold: count=%h required ffff", upd_count);
        end
        checks++;
        if (stored_bits !== m_bits) begin
            failures++;
            $display("FAIL sat_bits: bits=%h required %h", stored_bits, m_bits);
        end
    endtask

    initial begin
        flush_req     = 1'b0;
        upd.upd_valid = 1'b0;
        upd.upd_index = '0;
        upd.upd_way   = 1'b0;
        m_bits        = '0;
        m_count       = '0;
        test_reset();
        test_single_update();
        test_back_to_back();
        test_flush();
        test_reset_mid_flush();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
